// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and the response record.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Response record at the default width; the sequencer packs the same field order.
    typedef struct packed {
        logic [ALU_W-1:0] data;
        logic             zero;
        logic             lt;
        logic             err;
    } resp_t;

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO holding ALU responses until the consumer pops them.
module resp_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Drives one command at a time into a combinational ALU, checks its result against
// a local reference and queues {result, flags, err} in order for the consumer.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [W-1:0] CmdA,
    input  logic [W-1:0] CmdB,
    input  logic         CmdOp,
    output logic [W-1:0] AluA,
    output logic [W-1:0] AluB,
    output logic         AluOp,
    input  logic [W-1:0] AluOut,
    input  logic         AluZero,
    input  logic         AluLT,
    output logic         RespValid,
    input  logic         RespReady,
    output logic [W-1:0] RespData,
    output logic         RespZero,
    output logic         RespLT,
    output logic         RespErr,
    output logic [7:0]   OpCount,
    output logic [7:0]   ErrCount
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = W + 3;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_sel;
    logic [W-1:0]   expected;
    logic           result_err;
    logic           accept;
    logic           push;
    logic           pop;
    logic [RW-1:0]  push_data;
    logic [RW-1:0]  head_data;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ready depends only on registered FIFO occupancy, never on RespReady this cycle.
    always_comb begin
        state_nxt = state;
        CmdReady  = 1'b0;
        case (state)
            IDLE: begin
                CmdReady = (fifo_count < CW'(DEPTH));
                if (CmdValid && CmdReady) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = CmdValid && CmdReady;
    assign push   = (state == EXEC);
    assign pop    = RespValid && RespReady;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= ALU_ADD;
        end else if (accept) begin
            op_a   <= CmdA;
            op_b   <= CmdB;
            op_sel <= CmdOp;
        end
    end

    assign AluA  = op_a;
    assign AluB  = op_b;
    assign AluOp = op_sel;

    assign expected   = (op_sel == ALU_SUB) ? (op_a - op_b) : (op_a + op_b);
    assign result_err = (AluOut != expected);
    assign push_data  = {AluOut, AluZero, AluLT, result_err};

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            OpCount  <= '0;
            ErrCount <= '0;
        end else if (push) begin
            if (OpCount != 8'hFF) begin
                OpCount <= OpCount + 8'd1;
            end
            if (result_err && (ErrCount != 8'hFF)) begin
                ErrCount <= ErrCount + 8'd1;
            end
        end
    end

    resp_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_resp_fifo (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign RespValid = !fifo_empty;
    assign {RespData, RespZero, RespLT, RespErr} = head_data;

    // Admission control guarantees the EXEC push always finds space.
    a_no_push_when_full: assert property (@(posedge Clk) disable iff (!Reset_n) !(push && fifo_full));

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU that can be forced to return 0.
module tb_alu_seq;
    import alu_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       CmdValid;
    logic       CmdReady;
    logic [7:0] CmdA;
    logic [7:0] CmdB;
    logic       CmdOp;
    logic [7:0] AluA;
    logic [7:0] AluB;
    logic       AluOp;
    logic [7:0] AluOut;
    logic       AluZero;
    logic       AluLT;
    logic       RespValid;
    logic       RespReady;
    logic [7:0] RespData;
    logic       RespZero;
    logic       RespLT;
    logic       RespErr;
    logic [7:0] OpCount;
    logic [7:0] ErrCount;

    logic       faultZero;
    int         checkCount = 0;
    int         errorCount = 0;

    always #5 Clk = ~Clk;

    alu_seq #(.W(8), .DEPTH(2)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdA      (CmdA),
        .CmdB      (CmdB),
        .CmdOp     (CmdOp),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluOp     (AluOp),
        .AluOut    (AluOut),
        .AluZero   (AluZero),
        .AluLT     (AluLT),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespData  (RespData),
        .RespZero  (RespZero),
        .RespLT    (RespLT),
        .RespErr   (RespErr),
        .OpCount   (OpCount),
        .ErrCount  (ErrCount)
    );

    always_comb begin
        AluOut  = faultZero ? 8'h00 : (AluOp ? (AluA - AluB) : (AluA + AluB));
        AluZero = (AluOut == 8'h00);
        AluLT   = (AluA < AluB);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a command and returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b, input logic op);
        int waitCycles = 0;
        CmdA     = a;
        CmdB     = b;
        CmdOp    = op;
        CmdValid = 1'b1;
        while (!CmdReady && waitCycles < 20) begin
            @(negedge Clk);
            waitCycles++;
        end
        if (!CmdReady) begin
            checkOutput({tag, "_accept_timeout"}, 32'(CmdReady), 32'd1);
        end
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0;
    endtask

    task automatic checkResponse(input string tag, input logic [7:0] expData, input logic expZero, input logic expErr);
        int waitCycles = 0;
        while (!RespValid && waitCycles < 20) begin
            @(negedge Clk);
            waitCycles++;
        end
        checkOutput({tag, "_valid"}, 32'(RespValid), 32'd1);
        checkOutput({tag, "_data"}, 32'(RespData), 32'(expData));
        checkOutput({tag, "_zero"}, 32'(RespZero), 32'(expZero));
        checkOutput({tag, "_err"}, 32'(RespErr), 32'(expErr));
        RespReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        RespReady = 1'b0;
    endtask

    initial begin
        Reset_n   = 1'b0;
        CmdValid  = 1'b0;
        CmdA      = 8'h00;
        CmdB      = 8'h00;
        CmdOp     = ALU_ADD;
        RespReady = 1'b0;
        faultZero = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        checkOutput("rst_cmdready", 32'(CmdReady), 32'd1);
        checkOutput("rst_respvalid", 32'(RespValid), 32'd0);
        checkOutput("rst_opcount", 32'(OpCount), 32'd0);
        checkOutput("rst_errcount", 32'(ErrCount), 32'd0);
        checkOutput("rst_alua", 32'(AluA), 32'd0);
        checkOutput("rst_alub", 32'(AluB), 32'd0);
        checkOutput("rst_aluop", 32'(AluOp), 32'd0);

        // Basic ADD with latency and EXEC-phase checks.
        applyStimulus("add1", 8'h01, 8'h02, ALU_ADD);
        checkOutput("add1_exec_ready", 32'(CmdReady), 32'd0);
        checkOutput("add1_exec_valid", 32'(RespValid), 32'd0);
        checkOutput("add1_exec_alua", 32'(AluA), 32'h01);
        checkOutput("add1_exec_alub", 32'(AluB), 32'h02);
        @(negedge Clk);
        checkOutput("add1_latency", 32'(RespValid), 32'd1);
        checkResponse("add1", 8'h03, 1'b0, 1'b0);

        applyStimulus("sub1", 8'h02, 8'h01, ALU_SUB);
        checkResponse("sub1", 8'h01, 1'b0, 1'b0);
        applyStimulus("sub0", 8'h05, 8'h05, ALU_SUB);
        checkResponse("sub0", 8'h00, 1'b1, 1'b0);
        checkOutput("basic_opcount", 32'(OpCount), 32'd3);
        checkOutput("alu_hold_a", 32'(AluA), 32'h05);
        checkOutput("alu_hold_op", 32'(AluOp), 32'd1);

        applyStimulus("wrap_add", 8'hFF, 8'h01, ALU_ADD);
        checkResponse("wrap_add", 8'h00, 1'b1, 1'b0);
        applyStimulus("wrap_sub", 8'h00, 8'h01, ALU_SUB);
        checkResponse("wrap_sub", 8'hFF, 1'b0, 1'b0);

        // Backpressure: two responses fill the FIFO, third command must wait.
        applyStimulus("bp1", 8'h01, 8'h02, ALU_ADD);
        applyStimulus("bp2", 8'h04, 8'h03, ALU_ADD);
        @(negedge Clk);
        checkOutput("bp_full_ready", 32'(CmdReady), 32'd0);
        CmdA     = 8'h09;
        CmdB     = 8'h04;
        CmdOp    = ALU_SUB;
        CmdValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checkOutput($sformatf("bp_hold_ready%0d", i), 32'(CmdReady), 32'd0);
        end
        checkOutput("bp_head_data", 32'(RespData), 32'h03);
        RespReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        RespReady = 1'b0;
        checkOutput("bp_ready_after_pop", 32'(CmdReady), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        CmdValid = 1'b0;
        checkOutput("bp3_exec_ready", 32'(CmdReady), 32'd0);
        checkResponse("bp2", 8'h07, 1'b0, 1'b0);
        checkResponse("bp3", 8'h05, 1'b0, 1'b0);
        checkOutput("bp_opcount", 32'(OpCount), 32'd8);

        faultZero = 1'b1;
        applyStimulus("fault", 8'h01, 8'h02, ALU_ADD);
        checkResponse("fault", 8'h00, 1'b1, 1'b1);
        faultZero = 1'b0;
        checkOutput("fault_errcount", 32'(ErrCount), 32'd1);
        checkOutput("fault_opcount", 32'(OpCount), 32'd9);

        // Reset while the command is executing discards it.
        applyStimulus("midrst", 8'h03, 8'h04, ALU_ADD);
        Reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(RespValid), 32'd0);
        checkOutput("midrst_opcount", 32'(OpCount), 32'd0);
        checkOutput("midrst_errcount", 32'(ErrCount), 32'd0);
        checkOutput("midrst_alua", 32'(AluA), 32'd0);
        checkOutput("midrst_ready", 32'(CmdReady), 32'd1);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_no_resp", 32'(RespValid), 32'd0);
        applyStimulus("post", 8'h06, 8'h01, ALU_ADD);
        checkOutput("post_exec_valid", 32'(RespValid), 32'd0);
        @(negedge Clk);
        checkOutput("post_latency", 32'(RespValid), 32'd1);
        checkResponse("post", 8'h07, 1'b0, 1'b0);
        checkOutput("post_opcount", 32'(OpCount), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
